// File: rtl/seg7_scan_encoder.sv
// Recovers BCD digits from a time-multiplexed 7-segment scan stream and hands full frames downstream.
// Optional macro SEG7_ALT_GLYPH_EN accepts the alternate 6/7/9 glyphs as legal digits.
module seg7_scan_encoder #(
    parameter int N_DIGITS   = 4,
    parameter int STABLE_CNT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    seg_valid,
    output logic                    seg_ready,
    input  logic [6:0]              seg_in,
    input  logic [N_DIGITS-1:0]     dig_sel,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [4*N_DIGITS-1:0]   bcd_frame,
    output logic [N_DIGITS-1:0]     digit_err,
    output logic                    sel_err
);

    localparam int         WORD_W  = N_DIGITS + 7;
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [N_DIGITS-1:0]     seen_q, seen_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [WORD_W-1:0]       last_q, last_d;
    logic [4*N_DIGITS-1:0]   bcd_q, bcd_d;
    logic [N_DIGITS-1:0]     err_q, err_d;
    logic                    sel_err_q, sel_err_d;

    logic                    accept;
    logic [WORD_W-1:0]       word;
    logic [4:0]              glyph;

    // Returns {error, code}; blank is a legal "no digit" code 4'hA.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h7E:   r = {1'b0, 4'h0};
            7'h30:   r = {1'b0, 4'h1};
            7'h6D:   r = {1'b0, 4'h2};
            7'h79:   r = {1'b0, 4'h3};
            7'h33:   r = {1'b0, 4'h4};
            7'h5B:   r = {1'b0, 4'h5};
            7'h5F:   r = {1'b0, 4'h6};
            7'h70:   r = {1'b0, 4'h7};
            7'h7F:   r = {1'b0, 4'h8};
            7'h7B:   r = {1'b0, 4'h9};
            7'h00:   r = {1'b0, 4'hA};
`ifdef SEG7_ALT_GLYPH_EN
            7'h1F:   r = {1'b0, 4'h6};
            7'h72:   r = {1'b0, 4'h7};
            7'h73:   r = {1'b0, 4'h9};
`endif
            default: r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    function automatic logic is_onehot(input logic [N_DIGITS-1:0] sel);
        return $onehot(sel);
    endfunction

    assign accept = seg_valid && seg_ready;
    assign word   = {dig_sel, seg_in};
    assign glyph  = decode_glyph(seg_in);

    always_comb begin
        state_d   = state_q;
        seen_d    = seen_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        bcd_d     = bcd_q;
        err_d     = err_q;
        sel_err_d = 1'b0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (!is_onehot(dig_sel)) begin
                        sel_err_d = 1'b1;
                    end else begin
                        if (word == last_q) begin
                            if (cnt_q < CNT_MAX) cnt_d = cnt_q + 4'd1;
                        end else begin
                            last_d = word;
                            cnt_d  = 4'd1;
                        end
                        // Saturated repeats land here every time and simply re-commit.
                        if (cnt_d == CNT_MAX) begin
                            for (int i = 0; i < N_DIGITS; i++) begin
                                if (dig_sel[i]) begin
                                    bcd_d[4*i +: 4] = glyph[3:0];
                                    err_d[i]        = glyph[4];
                                    seen_d[i]       = 1'b1;
                                end
                            end
                            if (&seen_d) state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    state_d = COLLECT;
                    seen_d  = '0;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            seen_q    <= '0;
            cnt_q     <= 4'd0;
            last_q    <= '0;
            bcd_q     <= '0;
            err_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seen_q    <= seen_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            bcd_q     <= bcd_d;
            err_q     <= err_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Handshake outputs come straight from the state register, never from seg_valid.
    assign seg_ready   = (state_q == COLLECT);
    assign frame_valid = (state_q == HOLD);
    assign bcd_frame   = bcd_q;
    assign digit_err   = err_q;
    assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// Scoreboard bench for seg7_scan_encoder (N_DIGITS=4, STABLE_CNT=2); honours SEG7_ALT_GLYPH_EN.
module tb_seg7_scan_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seg_valid = 1'b0;
    logic        seg_ready;
    logic [6:0]  seg_in = 7'h00;
    logic [3:0]  dig_sel = 4'h0;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic [15:0] bcd_frame;
    logic [3:0]  digit_err;
    logic        sel_err;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    seg7_scan_encoder #(.N_DIGITS(4), .STABLE_CNT(2)) dut (
        .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .seg_in(seg_in), .dig_sel(dig_sel), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .bcd_frame(bcd_frame), .digit_err(digit_err),
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    // Presents one word, waits (bounded) for seg_ready, returns 1 ns after the accepting edge.
    task automatic send(input logic [3:0] sel, input logic [6:0] seg);
        int w = 0;
        @(negedge clk);
        dig_sel = sel; seg_in = seg; seg_valid = 1'b1;
        while (!seg_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: seg_ready=%0b, required 1 within 50 cycles", seg_ready);
        end
        @(posedge clk); #1;
        seg_valid = 1'b0;
    endtask

    task automatic send2(input logic [3:0] sel, input logic [6:0] seg);
        send(sel, seg);
        send(sel, seg);
    endtask

    task automatic release_frame();
        @(negedge clk);
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({seg_ready, frame_valid, bcd_frame, digit_err, sel_err} !== {1'b1, 1'b0, 16'h0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: rdy=%0b fv=%0b bcd=%h err=%b sel=%0b, required 1 0 0000 0000 0",
                     seg_ready, frame_valid, bcd_frame, digit_err, sel_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        exp_t e;
        exp_q.push_back('{bcd: 16'h4321, err: 4'h0});
        send2(4'b0001, 7'h30);
        send2(4'b0010, 7'h6D);
        send2(4'b0100, 7'h79);
        send(4'b1000, 7'h33);
        vectors++;
        if ({frame_valid, seg_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL basic_7th: fv/rdy=%b, required 01", {frame_valid, seg_ready});
        end
        send(4'b1000, 7'h33);
        vectors++;
        if ({frame_valid, seg_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_8th: fv/rdy=%b, required 10", {frame_valid, seg_ready});
        end
        e = exp_q.pop_front();
        vectors++;
        if ({bcd_frame, digit_err} !== {e.bcd, e.err}) begin
            miscompares++;
            $display("FAIL basic_frame: bcd=%h err=%b, required %h %b", bcd_frame, digit_err, e.bcd, e.err);
        end
    endtask

    task automatic test_hold_backpressure();
        exp_t e;
        @(negedge clk);
        dig_sel = 4'b0001; seg_in = 7'h7E; seg_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({frame_valid, seg_ready, bcd_frame} !== {1'b1, 1'b0, 16'h4321}) begin
                miscompares++;
                $display("FAIL hold_stall: fv=%0b rdy=%0b bcd=%h, required 1 0 4321", frame_valid, seg_ready, bcd_frame);
            end
        end
        release_frame();
        vectors++;
        if ({frame_valid, seg_ready, dut.seen_q} !== {1'b0, 1'b1, 4'h0}) begin
            miscompares++;
            $display("FAIL hold_release: fv=%0b rdy=%0b seen=%b, required 0 1 0000", frame_valid, seg_ready, dut.seen_q);
        end
        // Held word is still presented: first accept arms the counter, second commits slot 0.
        @(posedge clk); #1;
        vectors++;
        if (dut.seen_q !== 4'b0000) begin
            miscompares++;
            $display("FAIL held_first: seen=%b, required 0000", dut.seen_q);
        end
        @(posedge clk); #1;
        seg_valid = 1'b0;
        vectors++;
        if ({dut.seen_q, bcd_frame[3:0]} !== {4'b0001, 4'h0}) begin
            miscompares++;
            $display("FAIL held_commit: seen=%b slot0=%h, required 0001 0", dut.seen_q, bcd_frame[3:0]);
        end
        exp_q.push_back('{bcd: 16'h9850, err: 4'h0});
        send2(4'b0010, 7'h5B);
        send2(4'b0100, 7'h7F);
        send2(4'b1000, 7'h7B);
        e = exp_q.pop_front();
        vectors++;
        if ({frame_valid, bcd_frame, digit_err} !== {1'b1, e.bcd, e.err}) begin
            miscompares++;
            $display("FAIL hold_frame2: fv=%0b bcd=%h err=%b, required 1 %h %b", frame_valid, bcd_frame, digit_err, e.bcd, e.err);
        end
        release_frame();
    endtask

    task automatic test_glitch();
        exp_t e;
        exp_q.push_back('{bcd: 16'h3210, err: 4'h0});
        send(4'b0001, 7'h30);
        send(4'b0001, 7'h7E);
        vectors++;
        if (dut.seen_q !== 4'b0000) begin
            miscompares++;
            $display("FAIL glitch_seen2: seen=%b, required 0000", dut.seen_q);
        end
        send(4'b0001, 7'h7E);
        vectors++;
        if ({dut.seen_q, bcd_frame[3:0]} !== {4'b0001, 4'h0}) begin
            miscompares++;
            $display("FAIL glitch_seen3: seen=%b slot0=%h, required 0001 0", dut.seen_q, bcd_frame[3:0]);
        end
        send2(4'b0010, 7'h30);
        send2(4'b0100, 7'h6D);
        send2(4'b1000, 7'h79);
        e = exp_q.pop_front();
        vectors++;
        if ({frame_valid, bcd_frame, digit_err} !== {1'b1, e.bcd, e.err}) begin
            miscompares++;
            $display("FAIL glitch_frame: fv=%0b bcd=%h err=%b, required 1 %h %b", frame_valid, bcd_frame, digit_err, e.bcd, e.err);
        end
        release_frame();
    endtask

    task automatic test_illegal_blank();
        exp_t e;
        exp_q.push_back('{bcd: 16'hAF76, err: 4'b0100});
        send2(4'b0001, 7'h5F);
        send2(4'b0010, 7'h70);
        send2(4'b0100, 7'h01);
        send2(4'b1000, 7'h00);
        e = exp_q.pop_front();
        vectors++;
        if ({frame_valid, bcd_frame, digit_err} !== {1'b1, e.bcd, e.err}) begin
            miscompares++;
            $display("FAIL illegal_blank: fv=%0b bcd=%h err=%b, required 1 %h %b", frame_valid, bcd_frame, digit_err, e.bcd, e.err);
        end
        release_frame();
    endtask

    task automatic test_overwrite();
        exp_t e;
        exp_q.push_back('{bcd: 16'h8765, err: 4'h0});
        send2(4'b0001, 7'h30);
        send(4'b0001, 7'h30);
        vectors++;
        if ({dut.cnt_q, bcd_frame[3:0]} !== {4'd2, 4'h1}) begin
            miscompares++;
            $display("FAIL saturate: cnt=%0d slot0=%h, required 2 1", dut.cnt_q, bcd_frame[3:0]);
        end
        send2(4'b0001, 7'h5B);
        send2(4'b0010, 7'h5F);
        send2(4'b0100, 7'h70);
        send2(4'b1000, 7'h7F);
        e = exp_q.pop_front();
        vectors++;
        if ({frame_valid, bcd_frame, digit_err} !== {1'b1, e.bcd, e.err}) begin
            miscompares++;
            $display("FAIL overwrite: fv=%0b bcd=%h err=%b, required 1 %h %b", frame_valid, bcd_frame, digit_err, e.bcd, e.err);
        end
        release_frame();
    endtask

    task automatic test_sel_err_and_reset();
        send2(4'b0001, 7'h30);
        send(4'b0011, 7'h30);
        vectors++;
        if ({sel_err, dut.seen_q, dut.cnt_q} !== {1'b1, 4'b0001, 4'd2}) begin
            miscompares++;
            $display("FAIL sel_err_pulse: sel=%0b seen=%b cnt=%0d, required 1 0001 2", sel_err, dut.seen_q, dut.cnt_q);
        end
        @(posedge clk); #1;
        vectors++;
        if (sel_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sel_err_width: sel=%0b, required 0", sel_err);
        end
        send(4'b0000, 7'h7E);
        vectors++;
        if ({sel_err, dut.seen_q, dut.cnt_q} !== {1'b1, 4'b0001, 4'd2}) begin
            miscompares++;
            $display("FAIL sel_err_zero: sel=%0b seen=%b cnt=%0d, required 1 0001 2", sel_err, dut.seen_q, dut.cnt_q);
        end
        send2(4'b0010, 7'h6D);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({seg_ready, frame_valid, bcd_frame, digit_err, sel_err, dut.seen_q, dut.cnt_q} !==
            {1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'd0}) begin
            miscompares++;
            $display("FAIL async_reset: rdy=%0b fv=%0b bcd=%h err=%b sel=%0b seen=%b cnt=%0d, required 1 0 0000 0000 0 0000 0",
                     seg_ready, frame_valid, bcd_frame, digit_err, sel_err, dut.seen_q, dut.cnt_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alt_glyph();
        exp_t e;
`ifdef SEG7_ALT_GLYPH_EN
        exp_q.push_back('{bcd: 16'h0976, err: 4'b0000});
`else
        exp_q.push_back('{bcd: 16'h0FFF, err: 4'b0111});
`endif
        send2(4'b0001, 7'h1F);
        send2(4'b0010, 7'h72);
        send2(4'b0100, 7'h73);
        send2(4'b1000, 7'h7E);
        e = exp_q.pop_front();
        vectors++;
        if ({frame_valid, bcd_frame, digit_err} !== {1'b1, e.bcd, e.err}) begin
            miscompares++;
            $display("FAIL alt_glyph: fv=%0b bcd=%h err=%b, required 1 %h %b", frame_valid, bcd_frame, digit_err, e.bcd, e.err);
        end
        release_frame();
        vectors++;
        if ({frame_valid, seg_ready, bcd_frame} !== {1'b0, 1'b1, e.bcd}) begin
            miscompares++;
            $display("FAIL alt_release: fv=%0b rdy=%0b bcd=%h, required 0 1 %h", frame_valid, seg_ready, bcd_frame, e.bcd);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_hold_backpressure();
        test_glitch();
        test_illegal_blank();
        test_overwrite();
        test_sel_err_and_reset();
        test_alt_glyph();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
